// File: rtl/switch_seq_pkg.sv
// Shared types for the switch sequence driver.
// Define STATE_CHECK_EN to carry an expected FSM state with every command.
package switch_seq_pkg;

    localparam int SW_COUNT   = 5;
    localparam int SW_IDX_W   = 3;
    localparam int CMD_HOLD_W = 4;
    localparam int STATE_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [SW_IDX_W-1:0]   sw;
        logic [CMD_HOLD_W-1:0] hold;
`ifdef STATE_CHECK_EN
        logic [STATE_W-1:0]    exp;
`endif
    } seq_cmd_t;

    function automatic logic [SW_COUNT-1:0] sw_onehot(
        input logic [SW_IDX_W-1:0] idx
    );
        return SW_COUNT'(1) << idx;
    endfunction

endpackage

// File: rtl/seq_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags.
// Reset flushes the contents by clearing both pointers.
module seq_cmd_fifo
    import switch_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         do_push;
    logic         do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Extra pointer bit separates the full and empty cases.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/switch_seq_driver.sv
// Queues (switch, hold) commands and plays them as one-hot switch pulses.
// Define STATE_CHECK_EN to add the post-pulse FSM state compare.
module switch_seq_driver
    import switch_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int HOLD_W  = CMD_HOLD_W,
    parameter int GAP_CYC = 1
) (
    input  logic              KEY0,
    input  logic              KEY1,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_sw,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              SW0,
    output logic              SW1,
    output logic              SW2,
    output logic              SW3,
    output logic              SW4,
    output logic              busy,
    output logic              err
`ifdef STATE_CHECK_EN
    ,
    input  logic [2:0]        State_in,
    input  logic [2:0]        cmd_exp,
    output logic              chk_fail,
    output logic              chk_pass
`endif
);

    localparam int CMD_W = $bits(seq_cmd_t);
    localparam int GW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LOAD =
        GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    seq_state_e          state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [SW_COUNT-1:0] sw_q, sw_d;
    logic                err_q, err_d;

    seq_cmd_t            push_cmd;
    seq_cmd_t            head;
    logic [CMD_W-1:0]    head_bits;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                pop_ok;
    logic                expire;
    logic [HOLD_W-1:0]   hold_ld;

    always_comb begin
        push_cmd.sw   = cmd_sw;
        push_cmd.hold = cmd_hold;
`ifdef STATE_CHECK_EN
        push_cmd.exp  = cmd_exp;
`endif
    end

    seq_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk_i   (KEY0),
        .rst_i   (KEY1),
        .push_i  (cmd_valid),
        .wdata_i (push_cmd),
        .pop_i   (pop),
        .rdata_o (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head      = seq_cmd_t'(head_bits);
    assign cmd_ready = !fifo_full;

    // Commands are only taken from the FIFO while idle.
    assign pop     = (state_q == ST_IDLE) && !fifo_empty;
    assign pop_ok  = pop && (head.sw < SW_IDX_W'(SW_COUNT));
    assign expire  = (state_q == ST_DRIVE) && (hold_q <= HOLD_W'(1));
    assign hold_ld = (head.hold == '0) ? HOLD_W'(1) : head.hold;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        sw_d    = sw_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pop_ok) begin
                    sw_d    = sw_onehot(head.sw);
                    hold_d  = hold_ld;
                    state_d = ST_DRIVE;
                end else if (pop) begin
                    err_d = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (expire) begin
                    sw_d    = '0;
                    gap_d   = GAP_LOAD;
                    state_d = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                sw_d    = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge KEY0 or posedge KEY1) begin
        if (KEY1) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            gap_q   <= '0;
            sw_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            sw_q    <= sw_d;
            err_q   <= err_d;
        end
    end

    assign SW0  = sw_q[0];
    assign SW1  = sw_q[1];
    assign SW2  = sw_q[2];
    assign SW3  = sw_q[3];
    assign SW4  = sw_q[4];
    assign err  = err_q;
    assign busy = (state_q != ST_IDLE) || !fifo_empty;

`ifdef STATE_CHECK_EN
    logic [STATE_W-1:0] exp_q, exp_d;
    logic               arm_q, arm_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;

    // The compare fires on the edge right after the switch drops.
    always_comb begin
        exp_d  = pop_ok ? head.exp : exp_q;
        arm_d  = expire;
        pass_d = arm_q && (State_in == exp_q);
        fail_d = fail_q || (arm_q && (State_in != exp_q));
    end

    always_ff @(posedge KEY0 or posedge KEY1) begin
        if (KEY1) begin
            exp_q  <= '0;
            arm_q  <= 1'b0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            exp_q  <= exp_d;
            arm_q  <= arm_d;
            pass_q <= pass_d;
            fail_q <= fail_d;
        end
    end

    assign chk_pass = pass_q;
    assign chk_fail = fail_q;
`endif

endmodule

// File: tb/tb_switch_seq_driver.sv
// Randomized bench for switch_seq_driver against a pulse-schedule model.
// Define STATE_CHECK_EN to also exercise the state compare ports.
module tb_switch_seq_driver;

    localparam int DEPTH   = 4;
    localparam int HOLD_W  = 4;
    localparam int GAP_CYC = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_sw = '0;
    logic [HOLD_W-1:0] cmd_hold = '0;
    logic              sw0, sw1, sw2, sw3, sw4;
    logic              busy, err;
    logic [4:0]        sw_vec;
`ifdef STATE_CHECK_EN
    logic [2:0]        state_in = '0;
    logic [2:0]        cmd_exp = '0;
    logic              chk_fail, chk_pass;
`endif

    switch_seq_driver #(
        .DEPTH   (DEPTH),
        .HOLD_W  (HOLD_W),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .KEY0      (clk),
        .KEY1      (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sw    (cmd_sw),
        .cmd_hold  (cmd_hold),
        .SW0       (sw0),
        .SW1       (sw1),
        .SW2       (sw2),
        .SW3       (sw3),
        .SW4       (sw4),
        .busy      (busy),
        .err       (err)
`ifdef STATE_CHECK_EN
        ,
        .State_in  (state_in),
        .cmd_exp   (cmd_exp),
        .chk_fail  (chk_fail),
        .chk_pass  (chk_pass)
`endif
    );

    assign sw_vec = {sw4, sw3, sw2, sw1, sw0};

    always #5 clk = ~clk;

    int nchecks = 0;
    int nfail = 0;
    int cyc = 0;
    int next_free = 0;

    // One accepted command: edge accepted, edge popped, pulse length.
    typedef struct {
        int acc;
        int st;
        int h;
        int idx;
        bit ok;
    } mcmd_t;

    mcmd_t mq[$];

    task automatic check_eq(input string tag,
                            input logic [31:0] got,
                            input logic [31:0] want);
        nchecks++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h",
                     tag, cyc, got, want);
        end
    endtask

    function automatic bit mdl_ready();
        int n = 0;
        foreach (mq[i]) if (mq[i].st > cyc) n++;
        return n < DEPTH;
    endfunction

    function automatic logic [4:0] mdl_sw();
        logic [4:0] v = '0;
        foreach (mq[i])
            if (mq[i].ok && mq[i].st <= cyc &&
                cyc < mq[i].st + mq[i].h)
                v[mq[i].idx] = 1'b1;
        return v;
    endfunction

    function automatic bit mdl_err();
        bit e = 0;
        foreach (mq[i]) if (!mq[i].ok && mq[i].st == cyc) e = 1;
        return e;
    endfunction

    function automatic bit mdl_busy();
        bit b = 0;
        foreach (mq[i]) begin
            if (mq[i].st > cyc) b = 1;
            if (mq[i].ok && mq[i].st <= cyc &&
                cyc < mq[i].st + mq[i].h + GAP_CYC)
                b = 1;
        end
        return b;
    endfunction

    task automatic mdl_push(input int s, input int h);
        mcmd_t c;
        c.acc = cyc;
        c.st = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        c.idx = s;
        c.ok = (s < 5);
        c.h = (h == 0) ? 1 : h;
        next_free = c.ok ? c.st + c.h + GAP_CYC + 1 : c.st + 1;
        mq.push_back(c);
    endtask

    task automatic tick();
        bit acc;
        int s, h;
        acc = cmd_valid && mdl_ready();
        check_eq("cmd_ready", {31'b0, cmd_ready}, {31'b0, mdl_ready()});
        s = int'(cmd_sw);
        h = int'(cmd_hold);
        @(posedge clk);
        cyc++;
        if (acc) mdl_push(s, h);
        #1;
        check_eq("sw", {27'b0, sw_vec}, {27'b0, mdl_sw()});
        check_eq("err", {31'b0, err}, {31'b0, mdl_err()});
        check_eq("busy", {31'b0, busy}, {31'b0, mdl_busy()});
        check_eq("onehot", {31'b0, ($countones(sw_vec) <= 1)}, 32'd1);
        while (mq.size() > 0 &&
               mq[0].st + mq[0].h + GAP_CYC + 2 < cyc)
            void'(mq.pop_front());
    endtask

    task automatic send(input int s, input int h);
        bit done = 0;
        cmd_valid = 1'b1;
        cmd_sw = 3'(s);
        cmd_hold = HOLD_W'(h);
        for (int i = 0; i < 300 && !done; i++) begin
            done = mdl_ready();
            tick();
        end
        cmd_valid = 1'b0;
        check_eq("accept", {31'b0, done}, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_sw", {27'b0, sw_vec}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_err", {31'b0, err}, 32'd0);
        check_eq("rst_ready", {31'b0, cmd_ready}, 32'd1);
        mq.delete();
        next_free = 0;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("reset_sw", {27'b0, sw_vec}, 32'd0);
        check_eq("reset_busy", {31'b0, busy}, 32'd0);
        check_eq("reset_err", {31'b0, err}, 32'd0);
        check_eq("reset_ready", {31'b0, cmd_ready}, 32'd1);

        send(0, 1);
        idle(8);

        send(2, 3);
        send(1, 2);
        idle(12);

        for (int i = 0; i < 6; i++) send(i % 5, 15);
        idle(110);

        send(6, 2);
        send(4, 1);
        send(7, 0);
        send(3, 0);
        idle(10);

        send(3, 8);
        send(0, 2);
        send(1, 2);
        idle(2);
        check_eq("mid_drive_sw3", {27'b0, sw_vec}, 32'h8);
        pulse_reset();
        idle(30);

        for (int n = 0; n < 150; n++) begin
            int h;
            if ($urandom_range(0, 3) == 0) h = $urandom_range(0, 15);
            else h = $urandom_range(0, 3);
            send($urandom_range(0, 7), h);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
        end
        idle(120);

`ifdef STATE_CHECK_EN
        state_in = 3'd2;
        cmd_exp = 3'd2;
        send(0, 1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pulses += int'(chk_pass);
        end
        check_eq("chk_pass_pulses", pulses, 32'd1);
        check_eq("chk_fail_clear", {31'b0, chk_fail}, 32'd0);
        state_in = 3'd1;
        cmd_exp = 3'd3;
        send(1, 1);
        idle(8);
        check_eq("chk_fail_set", {31'b0, chk_fail}, 32'd1);
        idle(5);
        check_eq("chk_fail_sticky", {31'b0, chk_fail}, 32'd1);
        pulse_reset();
        check_eq("chk_fail_reset", {31'b0, chk_fail}, 32'd0);
`else
        pulses = 0;
        check_eq("no_pulse", pulses, {31'b0, err});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
